// File: rtl/lidar_pkg.sv
// rtl/lidar_pkg.sv - shared constants, state enum and helpers for the LiDAR frame parser
package lidar_pkg;

  localparam logic [7:0]  HDR0    = 8'h55;
  localparam logic [7:0]  HDR1    = 8'hAA;
  localparam logic [15:0] CS_SEED = 16'hAA55;

  typedef enum logic [3:0] {
    ST_HUNT0,
    ST_HUNT1,
    ST_CT,
    ST_LSN,
    ST_FSA_L,
    ST_FSA_H,
    ST_LSA_L,
    ST_LSA_H,
    ST_CS_L,
    ST_CS_H,
    ST_SAMP_L,
    ST_SAMP_H
  } parser_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CS      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic lsn_legal(input logic [7:0] lsn, input int max_samples);
    return (lsn != 8'd0) && (int'(lsn) <= max_samples);
  endfunction

endpackage

// File: rtl/lidar_frame_parser_if.sv
// rtl/lidar_frame_parser_if.sv - byte input and frame/sample output bundle for the parser
interface lidar_frame_parser_if;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_start;
  logic [7:0]  frame_ct;
  logic [7:0]  frame_lsn;
  logic [15:0] frame_fsa;
  logic [15:0] frame_lsa;
  logic        sample_valid;
  logic [15:0] sample_dist;
  logic [7:0]  sample_idx;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;

  modport master (
    output rx_byte, rx_valid,
    input  frame_start, frame_ct, frame_lsn, frame_fsa, frame_lsa,
    input  sample_valid, sample_dist, sample_idx,
    input  frame_done, frame_ok, err_code
  );

  modport slave (
    input  rx_byte, rx_valid,
    output frame_start, frame_ct, frame_lsn, frame_fsa, frame_lsa,
    output sample_valid, sample_dist, sample_idx,
    output frame_done, frame_ok, err_code
  );

endinterface

// File: rtl/lidar_frame_parser_byte_gap_timer.sv
// rtl/lidar_frame_parser_byte_gap_timer.sv - idle-cycle counter with terminal-count pulse
module byte_gap_timer #(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] count_q, count_d;

  // Terminal count ignores clr_i so a byte arriving on the expiry cycle loses.
  assign tc_o = en_i && (count_q == W'(TIMEOUT_CYC));

  always_comb begin
    count_d = count_q;
    if (!en_i || clr_i || tc_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lidar_frame_parser.sv
// rtl/lidar_frame_parser.sv - locks onto LiDAR packet headers, streams samples, checks checksum
module lidar_frame_parser
  import lidar_pkg::*;
#(
  parameter int MAX_SAMPLES = 40,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  lidar_frame_parser_if.slave  bus
);

  parser_state_e state_q, state_d;

  logic        timeout;
  logic        in_frame;
  logic        last_sample;
  logic [15:0] word;

  logic [7:0]  ct_q, ct_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] cs_q, cs_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_ct_q, frame_ct_d;
  logic [7:0]  frame_lsn_q, frame_lsn_d;
  logic [15:0] frame_fsa_q, frame_fsa_d;
  logic [15:0] frame_lsa_q, frame_lsa_d;
  logic        sample_valid_q, sample_valid_d;
  logic [15:0] sample_dist_q, sample_dist_d;
  logic [7:0]  sample_idx_q, sample_idx_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [1:0]  err_code_q, err_code_d;

  byte_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (bus.rx_valid),
    .en_i  (state_q != ST_HUNT0),
    .tc_o  (timeout)
  );

  assign in_frame    = state_q inside {ST_FSA_L, ST_FSA_H, ST_LSA_L, ST_LSA_H,
                                       ST_CS_L, ST_CS_H, ST_SAMP_L, ST_SAMP_H};
  assign last_sample = ((cnt_q + 8'd1) == frame_lsn_q);
  assign word        = {bus.rx_byte, lo_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HUNT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_HUNT0;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        ST_HUNT0:  state_d = (bus.rx_byte == HDR0) ? ST_HUNT1 : ST_HUNT0;
        ST_HUNT1: begin
          if (bus.rx_byte == HDR1)      state_d = ST_CT;
          else if (bus.rx_byte == HDR0) state_d = ST_HUNT1;
          else                          state_d = ST_HUNT0;
        end
        ST_CT:     state_d = ST_LSN;
        ST_LSN:    state_d = lsn_legal(bus.rx_byte, MAX_SAMPLES) ? ST_FSA_L : ST_HUNT0;
        ST_FSA_L:  state_d = ST_FSA_H;
        ST_FSA_H:  state_d = ST_LSA_L;
        ST_LSA_L:  state_d = ST_LSA_H;
        ST_LSA_H:  state_d = ST_CS_L;
        ST_CS_L:   state_d = ST_CS_H;
        ST_CS_H:   state_d = ST_SAMP_L;
        ST_SAMP_L: state_d = ST_SAMP_H;
        ST_SAMP_H: state_d = last_sample ? ST_HUNT0 : ST_SAMP_L;
        default:   state_d = ST_HUNT0;
      endcase
    end
  end

  always_comb begin
    ct_d           = ct_q;
    lo_d           = lo_q;
    cs_d           = cs_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    frame_start_d  = 1'b0;
    frame_ct_d     = frame_ct_q;
    frame_lsn_d    = frame_lsn_q;
    frame_fsa_d    = frame_fsa_q;
    frame_lsa_d    = frame_lsa_q;
    sample_valid_d = 1'b0;
    sample_dist_d  = sample_dist_q;
    sample_idx_d   = sample_idx_q;
    frame_done_d   = 1'b0;
    frame_ok_d     = frame_ok_q;
    err_code_d     = err_code_q;

    if (timeout) begin
      // Only frames that already announced frame_start are closed with a done pulse.
      if (in_frame) begin
        frame_done_d = 1'b1;
        frame_ok_d   = 1'b0;
        err_code_d   = ERR_TIMEOUT;
      end
    end else if (bus.rx_valid) begin
      unique case (state_q)
        ST_HUNT1: begin
          if (bus.rx_byte == HDR1) acc_d = CS_SEED;
        end
        ST_CT: ct_d = bus.rx_byte;
        ST_LSN: begin
          if (lsn_legal(bus.rx_byte, MAX_SAMPLES)) begin
            frame_start_d = 1'b1;
            frame_ct_d    = ct_q;
            frame_lsn_d   = bus.rx_byte;
            acc_d         = acc_q ^ {bus.rx_byte, ct_q};
            cnt_d         = 8'd0;
          end
        end
        ST_FSA_L, ST_LSA_L, ST_CS_L, ST_SAMP_L: lo_d = bus.rx_byte;
        ST_FSA_H: begin
          frame_fsa_d = word;
          acc_d       = acc_q ^ word;
        end
        ST_LSA_H: begin
          frame_lsa_d = word;
          acc_d       = acc_q ^ word;
        end
        ST_CS_H: cs_d = word;
        ST_SAMP_H: begin
          acc_d          = acc_q ^ word;
          sample_valid_d = 1'b1;
          sample_dist_d  = word;
          sample_idx_d   = cnt_q;
          cnt_d          = cnt_q + 8'd1;
          if (last_sample) begin
            frame_done_d = 1'b1;
            frame_ok_d   = ((acc_q ^ word) == cs_q);
            err_code_d   = frame_ok_d ? ERR_NONE : ERR_CS;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ct_q           <= '0;
      lo_q           <= '0;
      cs_q           <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      frame_start_q  <= 1'b0;
      frame_ct_q     <= '0;
      frame_lsn_q    <= '0;
      frame_fsa_q    <= '0;
      frame_lsa_q    <= '0;
      sample_valid_q <= 1'b0;
      sample_dist_q  <= '0;
      sample_idx_q   <= '0;
      frame_done_q   <= 1'b0;
      frame_ok_q     <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      ct_q           <= ct_d;
      lo_q           <= lo_d;
      cs_q           <= cs_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      frame_start_q  <= frame_start_d;
      frame_ct_q     <= frame_ct_d;
      frame_lsn_q    <= frame_lsn_d;
      frame_fsa_q    <= frame_fsa_d;
      frame_lsa_q    <= frame_lsa_d;
      sample_valid_q <= sample_valid_d;
      sample_dist_q  <= sample_dist_d;
      sample_idx_q   <= sample_idx_d;
      frame_done_q   <= frame_done_d;
      frame_ok_q     <= frame_ok_d;
      err_code_q     <= err_code_d;
    end
  end

  assign bus.frame_start  = frame_start_q;
  assign bus.frame_ct     = frame_ct_q;
  assign bus.frame_lsn    = frame_lsn_q;
  assign bus.frame_fsa    = frame_fsa_q;
  assign bus.frame_lsa    = frame_lsa_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_dist  = sample_dist_q;
  assign bus.sample_idx   = sample_idx_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_ok     = frame_ok_q;
  assign bus.err_code     = err_code_q;

endmodule

// File: doc/lidar_frame_parser.md
Name: lidar_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver and upstream of the min/max-distance and obstacle-alert logic in the LiDAR scan path.
- Consumes a stream of received bytes and locks onto packet headers.
- Extracts packet fields, streams 16-bit distance samples with their index, and checks the packet checksum at the end of each frame.
- Resynchronises automatically on bad headers, illegal lengths and inter-byte timeouts.

Parameters:
- MAX_SAMPLES, 40, largest legal LSN (sample count); LSN above this is rejected.
- TIMEOUT_CYC, 20000, clk cycles without rx_valid before a partial frame is aborted (about 2 byte times at 100 MHz / 115200 baud).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_byte  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- frame_start  out  1  pulse: header, CT and a legal LSN accepted
- frame_ct  out  8  packet type byte, held until the next frame_start
- frame_lsn  out  8  sample count, held until the next frame_start
- frame_fsa  out  16  start angle, held until the next frame_start
- frame_lsa  out  16  end angle, held until the next frame_start
- sample_valid  out  1  pulse: sample_dist and sample_idx valid
- sample_dist  out  16  raw distance sample, little-endian assembled
- sample_idx  out  8  sample index, 0..LSN-1
- frame_done  out  1  pulse: frame ended, either complete or aborted
- frame_ok  out  1  qualifies frame_done: 1 means checksum matched
- err_code  out  2  qualifies frame_done: 0 none, 1 checksum, 2 timeout, 3 reserved

Behaviour:
- Reset: every output is 0; state is HUNT0; accumulators and counters are cleared.
- Byte format: header bytes 0x55 then 0xAA, then CT, LSN, FSA_L, FSA_H, LSA_L, LSA_H, CS_L, CS_H, then LSN samples of two bytes each (low byte first).
- States and transitions (a state advances only on rx_valid):
  - HUNT0: 0x55 goes to HUNT1; any other byte stays in HUNT0.
  - HUNT1: 0xAA goes to CT; 0x55 stays in HUNT1; any other byte goes to HUNT0.
  - CT goes to LSN.
  - LSN: 0 or >MAX_SAMPLES returns to HUNT0 silently, with no frame_start and no frame_done. A legal value latches the byte and goes to FSA_L.
  - FSA_L, FSA_H, LSA_L, LSA_H, CS_L, CS_H follow in sequence; CS_H goes to SAMP_L.
  - SAMP_L goes to SAMP_H.
  - SAMP_H goes to SAMP_L if more samples remain, otherwise to HUNT0.
- frame_start: registered, asserted the cycle after the legal-LSN byte strobe.
- frame_fsa and frame_lsa update the cycle after their high byte arrives.
- Checksum: a 16-bit XOR accumulator is seeded with 16'hAA55 at header acceptance, then XORed with {LSN,CT}, FSA, LSA and every sample word. The received CS word is excluded.
- sample_valid: pulses the cycle after the SAMP_H byte strobe; sample_idx increments per sample and restarts at 0 each frame.
- frame_done on the last sample: pulses in the same cycle as the last sample_valid.
  - frame_ok = (accumulator including last sample == CS).
  - err_code = 0 if the checksum matches, 1 if not.
- Samples are streamed before validation. Downstream must discard the frame's results on frame_done with frame_ok=0.
- Timeout: an idle counter clears on every rx_valid and counts only outside HUNT0. On reaching TIMEOUT_CYC:
  - from FSA_L or later (i.e. after frame_start): pulse frame_done with frame_ok=0, err_code=2;
  - from HUNT1, CT or LSN: no pulse;
  - in both cases return to HUNT0.
- A 0x55 inside a frame is treated as data, never as a resync.
- rx_valid in the same cycle as a timeout: the timeout wins and the byte is dropped.
- reset mid-frame: return to HUNT0 immediately; no frame_done is emitted.
- All field, index and checksum arithmetic is 16-bit or 8-bit modulo with no saturation.

Decomposition:
- Shared package lidar_pkg:
  - HDR0=8'h55, HDR1=8'hAA, CS_SEED=16'hAA55;
  - parser state enum (12 states);
  - err_code constants ERR_NONE, ERR_CS, ERR_TIMEOUT.
- Sub-module byte_gap_timer: idle counter with clear/enable inputs and a terminal-count pulse, parameterised by TIMEOUT_CYC.

Test Plan:
- Valid frame. Send 55 AA 01 02 34 12 78 56 18 EF 00 01 00 02. Expect:
  - frame_start once, with ct=01, lsn=02, fsa=1234, lsa=5678;
  - samples 0100 (idx0) and 0200 (idx1);
  - frame_done=1, frame_ok=1, err_code=0.
- Bad checksum. Same frame with CS bytes 19 EF -> both samples still stream; frame_done with frame_ok=0, err_code=1.
- Header resync. Send AA 55 55 AA followed by the valid frame body -> exactly one frame_start and frame_ok=1.
- Illegal LSN. Send 55 AA 01 00 … (LSN=0), then separately LSN=MAX_SAMPLES+1 -> no frame_start and no frame_done; the following valid frame parses normally.
- Timeout. Send the valid frame up to 78 56 18, then idle TIMEOUT_CYC cycles -> frame_done, frame_ok=0, err_code=2; the next valid frame is parsed with ok=1.
- Reset mid-frame. Assert reset after sample 0 -> all outputs are 0 the next cycle, no frame_done, and the next frame parses with sample_idx restarting at 0.
